addsub_pipe: RTL and testbench

Parametrised successor to the single-cycle start/valid adder. It is an elastic, LAT-stage pipelined arithmetic unit with a valid/ready handshake on both sides. It supports four operating modes: wrap add, wrap subtract, saturating add, and running accumulate. It sits between a producer and a consumer that may stall, and sustains one result per cycle.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_stage.sv | 31 +++
 rtl/addsub_pipe.sv | 82 ++++++++
 tb/tb_addsub_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types for the addsub_pipe arithmetic unit.
// Contents: mode_e operation select. Results travel through the pipeline
// packed as {ovf, y}, i.e. W+1 bits.
package addsub_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_SADD = 2'd2,
        MODE_ACC  = 2'd3
    } mode_e;

endpackage

// File: rtl/addsub_stage.sv
// addsub_stage: one elastic valid/ready register slot.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_data   upstream beat
//   out_ready           downstream can take this slot's beat
//   out_valid, out_data registered beat held by this slot
// The slot loads whenever it is empty or its beat leaves this cycle, which is
// exactly the upstream ready term the top level derives for this slot.
module addsub_stage #(
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!out_valid || out_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: elastic LAT-stage add / subtract / saturating add / accumulate.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    operand handshake (in_ready forced low in reset)
//   a, b, mode, acc_clr   operands, op select, accumulator clear
//   out_valid, out_ready  result handshake
//   y, ovf                result and its overflow/borrow/clamp flag
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int W   = 16,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   mode,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf
);

    mode_e        op;
    logic [W:0]   sum, diff, acc_sum, res;
    logic [W-1:0] acc_q;
    logic         fire;
    // vld[0]/dat[0] is the incoming beat, vld[i+1]/dat[i+1] is slot i
    logic [LAT:0] vld;
    logic [LAT:0] rdy;
    logic [W:0]   dat [LAT+1];

    assign op      = mode_e'(mode);
    assign sum     = {1'b0, a} + {1'b0, b};
    // top bit of the W+1 difference is the borrow
    assign diff    = {1'b0, a} - {1'b0, b};
    assign acc_sum = {1'b0, acc_clr ? {W{1'b0}} : acc_q} + {1'b0, a};
    assign res     = op == MODE_ADD  ? sum :
                     op == MODE_SUB  ? diff :
                     op == MODE_SADD ? (sum[W] ? {1'b1, {W{1'b1}}} : sum) :
                     acc_sum;

    // ready_i = !valid_i || ready_{i+1}, unrolled so that slot i is ready
    // unless it and every slot after it are full while out_ready is low
    always_comb begin
        rdy = {out_ready, {LAT{1'b0}}};
        for (int i = 0; i < LAT; i++)
            rdy[i] = out_ready || !(&(vld[LAT:1] | LAT'((1 << i) - 1)));
    end

    assign in_ready = rdy[0] && rst_n;
    assign fire     = in_valid && in_ready;
    assign vld[0]   = in_valid;
    assign dat[0]   = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else if (fire && op == MODE_ACC) acc_q <= acc_sum[W-1:0];
        else if (fire && acc_clr) acc_q <= '0;
    end

    for (genvar g = 0; g < LAT; g++) begin : g_stage
        addsub_stage #(.DW(W + 1)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[g]),
            .in_data   (dat[g]),
            .out_ready (rdy[g+1]),
            .out_valid (vld[g+1]),
            .out_data  (dat[g+1])
        );
    end

    assign out_valid = vld[LAT];
    assign y         = dat[LAT][W-1:0];
    assign ovf       = dat[LAT][W];

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: self-checking bench for addsub_pipe (W=16, LAT=2).
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int W   = 16;
    localparam int LAT = 2;

    logic         clk = 0, rst_n = 1;
    logic         in_valid = 0, in_ready, acc_clr = 0;
    logic         out_valid, out_ready = 0, ovf;
    logic [W-1:0] a = 0, b = 0, y;
    logic [1:0]   mode = 0;

    typedef struct {logic [W-1:0] y; logic ovf; int t;} exp_t;
    typedef struct {mode_e m; logic [W-1:0] a; logic [W-1:0] b; logic clr; logic [W-1:0] y; logic ovf;} vec_t;

    exp_t         q[$];
    vec_t         vecs[$];
    int           n_chk = 0, n_fail = 0, cyc = 0;
    bit           rand_rdy = 0, exact_lat = 0;
    logic [W-1:0] acc_m = 0;

    addsub_pipe #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // independent reference: integer arithmetic, then reduce to W bits
    function automatic void model(input mode_e m, input logic [W-1:0] va, input logic [W-1:0] vb,
                                  input logic clr, output logic [W-1:0] ey, output logic eo);
        int s;
        int base;
        base = clr ? 0 : int'(acc_m);
        case (m)
            MODE_ADD:  begin s = int'(va) + int'(vb); ey = W'(s); eo = s > 65535; end
            MODE_SUB:  begin s = int'(va) - int'(vb); ey = W'(s); eo = s < 0; end
            MODE_SADD: begin s = int'(va) + int'(vb); eo = s > 65535; ey = eo ? 16'hFFFF : W'(s); end
            default:   begin s = base + int'(va); ey = W'(s); eo = s > 65535; end
        endcase
        if (m == MODE_ACC) acc_m = ey;
        else if (clr) acc_m = '0;
    endfunction

    // output monitor: compares every consumed beat against the expected queue
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) check("unexpected_beat", 32'(out_valid), 32'd0);
            else begin
                e = q.pop_front();
                check("y", 32'(y), 32'(e.y));
                check("ovf", 32'(ovf), 32'(e.ovf));
                if (exact_lat) check("latency", cyc - e.t + 1, LAT);
            end
        end
    end

    task automatic send(input mode_e m, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic clr, input logic [W-1:0] ey, input logic eo);
        int n = 0;
        @(negedge clk);
        in_valid = 1; mode = m; a = va; b = vb; acc_clr = clr;
        #2;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("accept", 32'(in_ready), 32'd1);
        q.push_back('{ey, eo, cyc + 1});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int acc_cnt = 0, guard = 0;
        bit taken = 1;
        logic [W-1:0] ey;
        logic eo;

        vecs.push_back('{MODE_ADD,  16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0});
        vecs.push_back('{MODE_ADD,  16'hFFFF, 16'h0002, 1'b0, 16'h0001, 1'b1});
        vecs.push_back('{MODE_SUB,  16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1});
        vecs.push_back('{MODE_SADD, 16'hFFF0, 16'h0020, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{MODE_SADD, 16'h1000, 16'h0001, 1'b0, 16'h1001, 1'b0});
        vecs.push_back('{MODE_ACC,  16'h000A, 16'h0000, 1'b1, 16'h000A, 1'b0});
        vecs.push_back('{MODE_ACC,  16'h0014, 16'h0000, 1'b0, 16'h001E, 1'b0});
        vecs.push_back('{MODE_ACC,  16'h0005, 16'h0000, 1'b0, 16'h0023, 1'b0});
        vecs.push_back('{MODE_ADD,  16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0});
        vecs.push_back('{MODE_ACC,  16'h0000, 16'h0000, 1'b0, 16'h0023, 1'b0});
        vecs.push_back('{MODE_ADD,  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{MODE_ADD,  16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
        vecs.push_back('{MODE_SUB,  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{MODE_SUB,  16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1});
        vecs.push_back('{MODE_SUB,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{MODE_SADD, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{MODE_SADD, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0});
        vecs.push_back('{MODE_ACC,  16'hFFFF, 16'h0000, 1'b0, 16'h0022, 1'b1});
        vecs.push_back('{MODE_SUB,  16'h0009, 16'h0004, 1'b1, 16'h0005, 1'b0});
        vecs.push_back('{MODE_ACC,  16'h0003, 16'hFFFF, 1'b0, 16'h0003, 1'b0});

        // reset state
        #1 rst_n = 0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        #19 rst_n = 1;
        @(negedge clk);
        out_ready = 1;
        #2 check("idle_in_ready", 32'(in_ready), 32'd1);

        // single-beat latency: accept at t, out_valid after t+1
        exact_lat = 1;
        send(MODE_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
        @(posedge clk);
        #1 in_valid = 0;
        check("lat_after_t", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 check("lat_after_t1", 32'(out_valid), 32'd1);
        drain();

        // directed vector table, streamed back to back
        foreach (vecs[i]) send(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].clr, vecs[i].y, vecs[i].ovf);
        @(negedge clk) in_valid = 0;
        drain();
        exact_lat = 0;

        // backpressure: two slots fill, third beat waits, y holds
        @(negedge clk) out_ready = 0;
        send(MODE_ADD, 16'h0100, 16'h0001, 1'b0, 16'h0101, 1'b0);
        send(MODE_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        mode = MODE_ADD; a = 16'h1234; b = 16'h1111; acc_clr = 0; in_valid = 1;
        #2;
        repeat (3) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_y_hold", 32'(y), 32'h0101);
            check("bp_ovf_hold", 32'(ovf), 32'd0);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
            #2;
        end
        @(negedge clk) out_ready = 1;
        #2 check("bp_release_in_ready", 32'(in_ready), 32'd1);
        q.push_back('{16'h2345, 1'b0, cyc + 1});
        send(MODE_ADD, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
        @(negedge clk) in_valid = 0;
        drain();

        // random stream with random stalls on both sides
        rand_rdy = 1;
        while (acc_cnt < 200 && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (!in_valid || taken) begin
                in_valid = 1'($urandom_range(0, 1));
                mode = 2'($urandom_range(0, 3));
                a = W'($urandom);
                b = W'($urandom);
                acc_clr = (acc_cnt == 0) || ($urandom_range(0, 7) == 0);
                taken = 0;
            end
            #2;
            if (in_valid && in_ready) begin
                model(mode_e'(mode), a, b, acc_clr, ey, eo);
                q.push_back('{ey, eo, cyc + 1});
                acc_cnt++;
                taken = 1;
            end
        end
        check("random_beats", acc_cnt, 200);
        @(negedge clk);
        in_valid = 0;
        rand_rdy = 0;
        out_ready = 1;
        drain();

        // asynchronous reset with two beats in flight
        send(MODE_ADD, 16'h0011, 16'h0022, 1'b0, 16'h0033, 1'b0);
        send(MODE_SUB, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0);
        @(posedge clk);
        #2 in_valid = 0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 0;
        q.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            #2 check("no_stale_beat", 32'(out_valid), 32'd0);
        end
        send(MODE_ACC, 16'h0007, 16'h0055, 1'b0, 16'h0007, 1'b0);
        @(negedge clk) in_valid = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
